// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel, W-bit registered multiplexer with per-channel
// valid/ready handshakes. Each cycle one requesting channel is granted,
// chosen by round-robin or by fixed priority (channel 0 highest). The
// granted word is captured in a single output register that supports
// full throughput (drain and refill on the same edge).
module rr_mux_reg #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prio_mode,
    input  logic [N-1:0]       in_valid,
    input  logic [N*W-1:0]     in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    localparam int unsigned NU   = N;
    localparam int unsigned LAST = N - 1;

    logic [SEL_W-1:0] rr_ptr;
    logic             load_en;
    logic             any_req;
    logic             hi_found;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     grant;
    logic [W-1:0]     sel_data;
    logic [SEL_W-1:0] ptr_next;
    logic             xfer;

    // The output stage can take a word when empty or drained this cycle.
    assign load_en = !out_valid || out_ready;

    // Find the lowest requester overall and the lowest at or above rr_ptr.
    // A round-robin scan from rr_ptr with wrap is equivalent to taking the
    // first requester at/above rr_ptr, else the lowest requester overall;
    // this keeps every index constant after loop unrolling.
    always_comb begin
        any_req  = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (in_valid[i]) begin
                if (!any_req) begin
                    any_req = 1'b1;
                    lo_idx  = SEL_W'(i);
                end
                if (!hi_found && (i >= 32'(rr_ptr))) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end
            end
        end
    end

    // Choose the winner according to the current arbitration mode.
    always_comb begin
        grant_idx = lo_idx;
        if (!prio_mode && hi_found) begin
            grant_idx = hi_idx;
        end
    end

    // One-hot grant vector and the data word of the winning channel.
    always_comb begin
        grant    = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (any_req && (32'(grant_idx) == i)) begin
                grant[i] = 1'b1;
                sel_data = in_data[i*W +: W];
            end
        end
    end

    // Pointer moves just past the granted channel, wrapping after N-1.
    always_comb begin
        if (32'(grant_idx) == LAST) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + SEL_W'(1);
        end
    end

    // Ready is withheld during reset and whenever the output stage is full.
    always_comb begin
        in_ready = '0;
        if (load_en && !rst) begin
            in_ready = grant;
        end
    end

    assign xfer = |in_ready;

    // Output register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
            rr_ptr    <= ptr_next;
        end else if (load_en) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_rr_mux_reg;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             prio_mode;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_mux_reg #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .prio_mode (prio_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for
    // the following falling edge where outputs are sampled.
    task automatic cyc(input logic r, input logic p, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input logic ordy);
        @(posedge clk);
        #1;
        rst       = r;
        prio_mode = p;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
    endtask

    // Behavioural model: output register contents and the fairness pointer.
    bit         m_known = 0;
    bit         m_valid = 0;
    bit [W-1:0] m_data  = '0;
    int         m_sel   = 0;
    int         m_ptr   = 0;

    initial begin : model
        bit         n_known;
        bit         n_valid;
        bit [W-1:0] n_data;
        int         n_sel;
        int         n_ptr;
        bit         load;
        int         g;
        bit [N-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            load = !m_valid || out_ready;
            g = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = prio_mode ? k : (m_ptr + k) % N;
                if (g < 0 && in_valid[c]) g = c;
            end
            exp_rdy = '0;
            if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
            if (m_known) begin
                chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
                chk("m_out_valid", 32'(out_valid), 32'(m_valid));
                chk("m_out_data", 32'(out_data), 32'(m_data));
                chk("m_out_sel", 32'(out_sel), 32'(m_sel));
            end
            n_known = m_known; n_valid = m_valid; n_data = m_data;
            n_sel = m_sel; n_ptr = m_ptr;
            if (rst) begin
                n_known = 1; n_valid = 0; n_data = '0; n_sel = 0; n_ptr = 0;
            end else if (load && g >= 0) begin
                n_valid = 1;
                n_data  = in_data[g*W +: W];
                n_sel   = g;
                n_ptr   = (g + 1) % N;
            end else if (load) begin
                n_valid = 0;
            end
            @(posedge clk);
            m_known = n_known; m_valid = n_valid; m_data = n_data;
            m_sel = n_sel; m_ptr = n_ptr;
        end
    end

    logic [W-1:0]   tbl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [N*W-1:0] d1;
    logic [N*W-1:0] d2;

    initial begin : stim
        d1 = 32'h44332211;
        d2 = 32'h44A52211;
        rst = 1'b1; prio_mode = 1'b0; in_valid = 4'hF; in_data = d1; out_ready = 1'b1;

        // Reset and idle
        cyc(1, 0, 4'hF, d1, 1);
        chk("rst_ready0", 32'(in_ready), 32'h0);
        cyc(1, 0, 4'hF, d1, 1);
        chk("rst_ready1", 32'(in_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);
        cyc(0, 0, 4'h0, d1, 1);
        chk("idle_ready", 32'(in_ready), 32'h0);

        // Round-robin fairness with every channel requesting
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 4'hF, d1, 1);
            chk("rr_ready", 32'(in_ready), 32'(1) << (k % 4));
            if (k == 0) begin
                chk("rr_first_valid", 32'(out_valid), 32'h0);
            end else begin
                chk("rr_valid", 32'(out_valid), 32'h1);
                chk("rr_sel", 32'(out_sel), 32'((k - 1) % 4));
                chk("rr_data", 32'(out_data), 32'(tbl[(k - 1) % 4]));
            end
        end

        // Pointer skip and wrap
        cyc(0, 0, 4'b0110, d1, 1);
        chk("skip_ready1", 32'(in_ready), 32'b0010);
        chk("skip_sel3", 32'(out_sel), 32'd3);
        chk("skip_data44", 32'(out_data), 32'h44);
        cyc(0, 0, 4'b0110, d1, 1);
        chk("skip_ready2", 32'(in_ready), 32'b0100);
        chk("skip_sel1", 32'(out_sel), 32'd1);
        cyc(0, 0, 4'b1001, d1, 1);
        chk("wrap_ready3", 32'(in_ready), 32'b1000);
        chk("skip_sel2", 32'(out_sel), 32'd2);
        cyc(0, 0, 4'b1001, d1, 1);
        chk("wrap_ready0", 32'(in_ready), 32'b0001);
        chk("wrap_sel3", 32'(out_sel), 32'd3);

        // Fixed priority
        cyc(0, 1, 4'b1110, d1, 1);
        chk("fp_ready_a", 32'(in_ready), 32'b0010);
        chk("wrap_sel0", 32'(out_sel), 32'd0);
        chk("wrap_data11", 32'(out_data), 32'h11);
        cyc(0, 1, 4'b1110, d1, 1);
        chk("fp_ready_b", 32'(in_ready), 32'b0010);
        chk("fp_sel1", 32'(out_sel), 32'd1);
        cyc(0, 1, 4'b1100, d1, 1);
        chk("fp_ready_c", 32'(in_ready), 32'b0100);
        chk("fp_sel1b", 32'(out_sel), 32'd1);
        cyc(0, 1, 4'b0000, d1, 1);
        chk("fp_sel2", 32'(out_sel), 32'd2);
        chk("fp_data33", 32'(out_data), 32'h33);

        // Backpressure: load A5 from ch2, then stall
        cyc(0, 0, 4'b0100, d2, 1);
        chk("bp_load_ready", 32'(in_ready), 32'b0100);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 4'hF, d2, 0);
            chk("bp_ready", 32'(in_ready), 32'h0);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data", 32'(out_data), 32'hA5);
            chk("bp_sel", 32'(out_sel), 32'd2);
        end
        cyc(0, 0, 4'hF, d2, 1);
        chk("bp_release_ready", 32'(in_ready), 32'b1000);
        chk("bp_release_data", 32'(out_data), 32'hA5);
        cyc(0, 0, 4'hF, d2, 0);
        chk("bp_next_sel", 32'(out_sel), 32'd3);
        chk("bp_next_data", 32'(out_data), 32'h44);
        chk("bp_next_ready", 32'(in_ready), 32'h0);

        // Reset while a word is held under backpressure
        cyc(1, 0, 4'hF, d2, 0);
        chk("mid_rst_ready", 32'(in_ready), 32'h0);
        cyc(0, 0, 4'hF, d2, 0);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ready0", 32'(in_ready), 32'b0001);
        cyc(0, 0, 4'h0, d2, 1);
        chk("mid_rst_sel", 32'(out_sel), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'h11);

        // Randomized traffic, checked by the model process
        for (int k = 0; k < 3000; k++) begin
            logic           r;
            logic           p;
            logic [N-1:0]   v;
            logic           o;
            r = ($urandom_range(0, 99) == 0);
            p = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            o = ($urandom_range(0, 3) != 0);
            cyc(r, p, v, $urandom, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake.
- Selects one requesting channel per cycle, by round-robin or fixed priority, and registers its data into a single output stage.
- Successor to the 1-bit and 8-bit combinational mux cells; merges multiple producer streams into one consumer stream feeding the MAC datapath.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel (≥1).
- SEL_W, $clog2(N), width of the out_sel index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest).
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
- in_ready  output  N  one-hot or zero; channel i transfers when in_valid[i] && in_ready[i].
- out_valid  output  1  output register holds valid data.
- out_data  output  W  registered selected data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready is forced to all-zero combinationally while rst=1.
  - Reset mid-transfer discards the held word; no in_ready is asserted in that cycle.
- load_en = !out_valid || out_ready. The output stage accepts a new word only when it is empty or being drained in the same cycle. Full throughput is 1 word/cycle.
- Grant selection is combinational from in_valid, rr_ptr and prio_mode:
  - prio_mode=0: scan indices rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1 (mod N); grant the first with in_valid=1.
  - prio_mode=1: grant the lowest index with in_valid=1; rr_ptr is ignored for selection.
- in_ready[i] = load_en && grant[i] && !rst. At most one bit is set. If no in_valid is set, in_ready is all-zero.
- in_ready never depends on in_valid of the same channel except through grant. Producers must hold in_valid and in_data stable until the transfer.
- On a clk edge with a transfer from channel g:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - rr_ptr <= (g==N-1) ? 0 : g+1. This wrap-around applies in both modes, so switching back to round-robin resumes fairly.
- On a clk edge with load_en=1 and no transfer: out_valid <= 0. out_data and out_sel keep their last values.
- On a clk edge with load_en=0 (out_valid=1, out_ready=0):
  - All registers hold; rr_ptr holds.
  - in_ready is all-zero (backpressure).
- Simultaneous drain and fill (out_valid=1, out_ready=1, request present): the old word is consumed and the new word is loaded on the same edge. No bubble.
- Latency: 1 cycle from the in_valid&&in_ready edge to out_valid.
- prio_mode may change on any cycle. It takes effect on that cycle's combinational grant.
- Grants are fair in round-robin mode: with all N channels continuously requesting and out_ready=1, each channel is granted exactly once every N cycles.

Test Plan:
- Reset/idle: hold rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0. Release rst with in_valid=0 -> out_valid stays 0.
- Round-robin fairness (N=4, W=8): in_data = {8'h44,8'h33,8'h22,8'h11}, in_valid=1111, out_ready=1, prio_mode=0 -> out_sel sequence 0,1,2,3,0,… and out_data 11,22,33,44,11,… on consecutive cycles, no bubbles.
- Pointer skip/wrap: after a grant to ch3 (rr_ptr=0), drive in_valid=0110 -> grant ch1 then ch2. Then in_valid=1001 -> grant ch3, then ch0 (wrap).
- Fixed priority: prio_mode=1, in_valid=1110 continuously, out_ready=1 -> out_sel=1 every cycle. Drop in_valid[1] -> out_sel=2.
- Backpressure: load word 8'hA5 from ch2, then hold out_ready=0 for 3 cycles with in_valid=1111 -> out_valid=1, out_data=A5, out_sel=2 held, in_ready=0000. Raise out_ready -> the next grant (ch3 in RR) loads on that same edge.
- Reset mid-operation: with out_valid=1 and out_ready=0, assert rst for 1 cycle -> out_valid=0, rr_ptr=0. The first grant after release with in_valid=1111 is ch0.
